// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the ALU client units and alu_arbiter.
// The master side is the requesters; the slave side is the arbiter itself.
interface alu_arbiter_if #(
  parameter int CNTW = 8
);
  logic [1:0]      req;
  logic [1:0]      code0;
  logic [3:0]      a0;
  logic [3:0]      b0;
  logic [1:0]      code1;
  logic [3:0]      a1;
  logic [3:0]      b1;
  logic [1:0]      gnt;
  logic [1:0]      ack;
  logic [4:0]      result;
  logic            busy;
  logic [CNTW-1:0] opcnt;

  modport master (
    output req, code0, a0, b0, code1, a1, b1,
    input  gnt, ack, result, busy, opcnt
  );

  modport slave (
    input  req, code0, a0, b0, code1, a1, b1,
    output gnt, ack, result, busy, opcnt
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared 4-bit AND/OR/SUB/ADD ALU.
// One operation per grant: IDLE captures the winner's operands, EXEC computes, DONE acknowledges.
module alu_arbiter #(
  parameter int CNTW = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic            rr_q;
  logic            win_q;
  logic [1:0]      code_q;
  logic [3:0]      a_q;
  logic [3:0]      b_q;
  logic [1:0]      gnt_q;
  logic [1:0]      ack_q;
  logic [4:0]      result_q;
  logic            busy_q;
  logic [CNTW-1:0] opcnt_q;
  logic            win_d;

  // Operands are zero-extended, so bit 4 is carry for ADD and borrow for SUB.
  function automatic logic [4:0] alu_f(input logic [1:0] code,
                                       input logic [3:0] a,
                                       input logic [3:0] b);
    logic [4:0] ax;
    logic [4:0] bx;
    ax = {1'b0, a};
    bx = {1'b0, b};
    case (code)
      2'b00:   alu_f = ax & bx;
      2'b01:   alu_f = ax | bx;
      2'b10:   alu_f = ax - bx;
      2'b11:   alu_f = ax + bx;
      default: alu_f = 5'd0;
    endcase
  endfunction

  // Winner selection: a lone requester wins outright, a tie goes to the rr pointer.
  always_comb begin
    win_d = rr_q;
    if (bus.req == 2'b01) begin
      win_d = 1'b0;
    end else if (bus.req == 2'b10) begin
      win_d = 1'b1;
    end else begin
      win_d = rr_q;
    end
  end

  // Control FSM with all outputs registered; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      win_q    <= 1'b0;
      code_q   <= 2'b00;
      a_q      <= 4'd0;
      b_q      <= 4'd0;
      gnt_q    <= 2'b00;
      ack_q    <= 2'b00;
      result_q <= 5'd0;
      busy_q   <= 1'b0;
      opcnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req != 2'b00) begin
            win_q   <= win_d;
            code_q  <= win_d ? bus.code1 : bus.code0;
            a_q     <= win_d ? bus.a1 : bus.a0;
            b_q     <= win_d ? bus.b1 : bus.b0;
            gnt_q   <= win_d ? 2'b10 : 2'b01;
            busy_q  <= 1'b1;
            state_q <= EXEC;
          end else begin
            state_q <= IDLE;
          end
        end
        EXEC: begin
          // Counter and pointer move on entry to DONE so they are current while ack is high.
          result_q <= alu_f(code_q, a_q, b_q);
          ack_q    <= gnt_q;
          opcnt_q  <= opcnt_q + {{(CNTW-1){1'b0}}, 1'b1};
          rr_q     <= ~win_q;
          state_q  <= DONE;
        end
        DONE: begin
          ack_q   <= 2'b00;
          gnt_q   <= 2'b00;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          ack_q   <= 2'b00;
          gnt_q   <= 2'b00;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.ack    = ack_q;
  assign bus.result = result_q;
  assign bus.busy   = busy_q;
  assign bus.opcnt  = opcnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed stimulus pushes expected acks,
// a negedge monitor pops and compares whenever the DUT acknowledges.
module tb_alu_arbiter;

  logic clk;
  logic rst_n;

  alu_arbiter_if #(.CNTW(8)) dif ();
  alu_arbiter_if #(.CNTW(2)) wif ();

  alu_arbiter #(.CNTW(8)) dut (.clk(clk), .rst_n(rst_n), .bus(dif));
  alu_arbiter #(.CNTW(2)) dut_w (.clk(clk), .rst_n(rst_n), .bus(wif));

  typedef struct {
    logic [1:0] ack;
    logic [4:0] res;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] exp_cnt;
  int         total;
  int         bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic who, input logic [4:0] res);
    exp_t e;
    exp_cnt = exp_cnt + 8'd1;
    e.ack = who ? 2'b10 : 2'b01;
    e.res = res;
    e.cnt = exp_cnt;
    sb_q.push_back(e);
  endtask

  // Monitor: compare each ack against the scoreboard and check grant invariants.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dif.ack != 2'b00) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack: got ack=%b with empty scoreboard", dif.ack);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("ack", {30'd0, dif.ack}, {30'd0, e.ack});
          chk("result", {27'd0, dif.result}, {27'd0, e.res});
          chk("opcnt", {24'd0, dif.opcnt}, {24'd0, e.cnt});
        end
      end
      if (dif.busy) begin
        chk("gnt_onehot", {31'd0, $onehot(dif.gnt)}, 32'd1);
        chk("ack_in_gnt", {30'd0, dif.ack & ~dif.gnt}, 32'd0);
      end
      chk("busy_eq_gnt", {31'd0, dif.busy}, {31'd0, (dif.gnt != 2'b00)});
    end
  end

  task automatic wait_ack(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk);
      #1;
      if (dif.ack != 2'b00) got = 1'b1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no ack expected ack within 10 cycles", name);
    end
  endtask

  task automatic single_op(input logic who, input logic [1:0] code, input logic [3:0] a,
                           input logic [3:0] b, input logic [4:0] res, input string name);
    if (who) begin
      dif.code1 = code; dif.a1 = a; dif.b1 = b; dif.req = 2'b10;
    end else begin
      dif.code0 = code; dif.a0 = a; dif.b0 = b; dif.req = 2'b01;
    end
    push(who, res);
    wait_ack(name);
    dif.req = 2'b00;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] wrap_exp [5];
    bit got;
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    total = 0;
    bad = 0;
    exp_cnt = 8'd0;
    dif.req = 2'b00; dif.code0 = 2'b00; dif.a0 = 4'd0; dif.b0 = 4'd0;
    dif.code1 = 2'b00; dif.a1 = 4'd0; dif.b1 = 4'd0;
    wif.req = 2'b00; wif.code0 = 2'b11; wif.a0 = 4'd1; wif.b0 = 4'd1;
    wif.code1 = 2'b00; wif.a1 = 4'd0; wif.b1 = 4'd0;
    rst_n = 1'b0;
    #1;
    chk("rst_gnt", {30'd0, dif.gnt}, 32'd0);
    chk("rst_ack", {30'd0, dif.ack}, 32'd0);
    chk("rst_result", {27'd0, dif.result}, 32'd0);
    chk("rst_busy", {31'd0, dif.busy}, 32'd0);
    chk("rst_opcnt", {24'd0, dif.opcnt}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single ADD, then SUB with and without borrow.
    single_op(1'b0, 2'b11, 4'd9, 4'd8, 5'd17, "add");
    single_op(1'b1, 2'b10, 4'd3, 4'd5, 5'd30, "sub_borrow");
    single_op(1'b1, 2'b10, 4'd5, 4'd3, 5'd2, "sub");

    // Contention: rr is 0 here, so requester 0 goes first and grants alternate.
    dif.code0 = 2'b00; dif.a0 = 4'hF; dif.b0 = 4'h6;
    dif.code1 = 2'b01; dif.a1 = 4'h8; dif.b1 = 4'h1;
    push(1'b0, 5'd6); push(1'b1, 5'd9); push(1'b0, 5'd6); push(1'b1, 5'd9);
    dif.req = 2'b11;
    for (int k = 0; k < 4; k++) wait_ack("contention");
    dif.req = 2'b00;
    @(posedge clk);
    #1;

    // Operands change and req drops after capture: the captured 2+2 still completes.
    dif.code0 = 2'b11; dif.a0 = 4'd2; dif.b0 = 4'd2; dif.req = 2'b01;
    push(1'b0, 5'd4);
    @(posedge clk);
    #1;
    dif.a0 = 4'hF;
    dif.req = 2'b00;
    wait_ack("drop");
    @(posedge clk);
    #1;

    // Reset during EXEC clears everything at once; afterwards rr=0 gives requester 0 the tie.
    dif.code0 = 2'b11; dif.a0 = 4'd1; dif.b0 = 4'd2;
    dif.code1 = 2'b00; dif.a1 = 4'd7; dif.b1 = 4'd7;
    dif.req = 2'b11;
    @(posedge clk);
    #1;
    chk("exec_busy", {31'd0, dif.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", {30'd0, dif.gnt}, 32'd0);
    chk("mid_rst_busy", {31'd0, dif.busy}, 32'd0);
    chk("mid_rst_result", {27'd0, dif.result}, 32'd0);
    chk("mid_rst_ack", {30'd0, dif.ack}, 32'd0);
    sb_q.delete();
    exp_cnt = 8'd0;
    push(1'b0, 5'd3);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ack("post_rst");
    dif.req = 2'b00;
    @(posedge clk);
    #1;

    // Narrow counter wraps 1,2,3,0,1.
    for (int k = 0; k < 5; k++) begin
      wif.req = 2'b01;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(posedge clk);
        #1;
        if (wif.ack != 2'b00) got = 1'b1;
      end
      if (!got) begin
        total++;
        bad++;
        $display("FAIL wrap_timeout: got no ack expected ack within 10 cycles");
      end else begin
        chk("wrap_opcnt", {30'd0, wif.opcnt}, {30'd0, wrap_exp[k]});
        chk("wrap_result", {27'd0, wif.result}, 32'd2);
      end
      wif.req = 2'b00;
      @(posedge clk);
      #1;
    end

    repeat (4) @(posedge clk);
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
